amo_mem_responder: RTL

//  Memory-side responder for the core's atomic/data requests (the memory end of LR_W/SC_W/AMO_W).

---
 rtl/amo_mem_responder_pkg.sv | 38 +++
 rtl/amo_mem_responder_alu.sv | 27 ++
 rtl/amo_mem_responder.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/amo_mem_responder_pkg.sv
// rtl/amo_mem_responder_pkg.sv - request kinds, responder FSM states and atomic op encodings
package amo_mem_responder_pkg;

  typedef enum logic [2:0] {
    MREQ_LOAD  = 3'd0,
    MREQ_STORE = 3'd1,
    MREQ_LR    = 3'd2,
    MREQ_SC    = 3'd3,
    MREQ_AMO   = 3'd4
  } memReqKind_e;

  typedef enum logic [2:0] {
    R_IDLE  = 3'd0,
    R_READ  = 3'd1,
    R_LATCH = 3'd2,
    R_WRITE = 3'd3,
    R_RESP  = 3'd4
  } amo_rsp_states_e;

  typedef enum logic [9:0] {
    AMONOP  = 10'b00_0000_0001,
    AMOSWAP = 10'b00_0000_0010,
    AMOADD  = 10'b00_0000_0100,
    AMOXOR  = 10'b00_0000_1000,
    AMOAND  = 10'b00_0001_0000,
    AMOOR   = 10'b00_0010_0000,
    AMOMIN  = 10'b00_0100_0000,
    AMOMAX  = 10'b00_1000_0000,
    AMOMINU = 10'b01_0000_0000,
    AMOMAXU = 10'b10_0000_0000
  } iTypeAtomic_e;

  // Kinds that must be word aligned; the others silently drop addr[1:0].
  function automatic logic is_atomic_kind(memReqKind_e kind);
    return (kind == MREQ_LR) || (kind == MREQ_SC) || (kind == MREQ_AMO);
  endfunction

endpackage

// File: rtl/amo_mem_responder_alu.sv
// rtl/amo_mem_responder_alu.sv - amo_alu: combinational new-value computation for AMO read-modify-write
module amo_alu
  import amo_mem_responder_pkg::*;
(
  input  logic [31:0]  old_val,
  input  logic [31:0]  operand,
  input  iTypeAtomic_e op,
  output logic [31:0]  new_val
);

  always_comb begin
    new_val = old_val;
    case (op)
      AMOSWAP: new_val = operand;
      AMOADD:  new_val = old_val + operand;
      AMOXOR:  new_val = old_val ^ operand;
      AMOAND:  new_val = old_val & operand;
      AMOOR:   new_val = old_val | operand;
      AMOMIN:  new_val = ($signed(old_val) < $signed(operand)) ? old_val : operand;
      AMOMAX:  new_val = ($signed(old_val) > $signed(operand)) ? old_val : operand;
      AMOMINU: new_val = (old_val < operand) ? old_val : operand;
      AMOMAXU: new_val = (old_val > operand) ? old_val : operand;
      default: new_val = old_val;
    endcase
  end

endmodule

// File: rtl/amo_mem_responder.sv
// rtl/amo_mem_responder.sv - memory-side LR/SC/AMO responder in front of a 1-cycle sync RAM
// Optional reservation expiry when RSV_TIMEOUT_EN is defined.
module amo_mem_responder
  import amo_mem_responder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_kind_i,
  input  logic [9:0]  req_amo_op_i,
  input  logic [31:0] req_addr_i,
  input  logic [3:0]  req_be_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        mem_en_o,
  output logic [3:0]  mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

`ifdef RSV_TIMEOUT_EN
  parameter int unsigned RSV_TIMEOUT = 64;
`endif

  amo_rsp_states_e state_q, state_d;
  memReqKind_e     req_kind, kind_q;
  logic [9:0]      op_q;
  logic [29:0]     word_q;
  logic [3:0]      be_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;
  logic            err_q;

  logic            rsv_valid;
  logic [29:0]     rsv_addr;
  logic            rsv_expire;

  logic            accept;
  logic            misaligned;
  logic            sc_ok;
  logic            lr_set;
  logic            sc_accept;
  logic            wr_hit;
  logic [31:0]     amo_new;

  assign req_kind   = memReqKind_e'(req_kind_i);
  assign accept     = (state_q == R_IDLE) && req_valid_i;
  assign misaligned = is_atomic_kind(req_kind) && (req_addr_i[1:0] != 2'b00);
  // An expiry landing on the SC accept cycle wins, so the SC fails.
  assign sc_ok      = rsv_valid && !rsv_expire && (req_addr_i[31:2] == rsv_addr);

  assign lr_set     = (state_q == R_LATCH) && (kind_q == MREQ_LR);
  assign sc_accept  = accept && (req_kind == MREQ_SC);
  assign wr_hit     = (state_q == R_WRITE) && (kind_q != MREQ_SC) && (word_q == rsv_addr);

  amo_alu u_amo_alu (
    .old_val (rdata_q),
    .operand (wdata_q),
    .op      (iTypeAtomic_e'(op_q)),
    .new_val (amo_new)
  );

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_rdata_o = '0;
    rsp_err_o   = 1'b0;
    mem_en_o    = 1'b0;
    mem_we_o    = '0;
    mem_wdata_o = '0;
    case (state_q)
      R_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          if (misaligned) begin
            state_d = R_RESP;
          end else begin
            case (req_kind)
              MREQ_LOAD, MREQ_LR, MREQ_AMO: state_d = R_READ;
              MREQ_STORE:                   state_d = R_WRITE;
              MREQ_SC:                      state_d = sc_ok ? R_WRITE : R_RESP;
              default:                      state_d = R_RESP;
            endcase
          end
        end
      end
      R_READ: begin
        mem_en_o = 1'b1;
        state_d  = R_LATCH;
      end
      R_LATCH: begin
        state_d = (kind_q == MREQ_AMO) ? R_WRITE : R_RESP;
      end
      R_WRITE: begin
        mem_en_o    = 1'b1;
        mem_we_o    = (kind_q == MREQ_STORE) ? be_q : 4'hF;
        mem_wdata_o = (kind_q == MREQ_AMO) ? amo_new : wdata_q;
        state_d     = R_RESP;
      end
      R_RESP: begin
        rsp_valid_o = 1'b1;
        rsp_rdata_o = rdata_q;
        rsp_err_o   = err_q;
        if (rsp_ready_i) state_d = R_IDLE;
      end
      default: state_d = R_IDLE;
    endcase
  end

  assign mem_addr_o = {word_q, 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= R_IDLE;
      kind_q  <= MREQ_LOAD;
      op_q    <= '0;
      word_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        kind_q  <= req_kind;
        op_q    <= req_amo_op_i;
        word_q  <= req_addr_i[31:2];
        be_q    <= req_be_i;
        wdata_q <= req_wdata_i;
        err_q   <= misaligned;
        // SC status is decided here; every other kind starts from 0 and LATCH fills in read data.
        rdata_q <= (req_kind == MREQ_SC && !misaligned && !sc_ok) ? 32'd1 : 32'd0;
      end else if (state_q == R_LATCH) begin
        rdata_q <= mem_rdata_i;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsv_valid <= 1'b0;
      rsv_addr  <= '0;
    end else if (lr_set) begin
      rsv_valid <= 1'b1;
      rsv_addr  <= word_q;
    end else if (sc_accept || wr_hit || rsv_expire) begin
      rsv_valid <= 1'b0;
    end
  end

`ifdef RSV_TIMEOUT_EN
  localparam int unsigned CNT_W = (RSV_TIMEOUT > 1) ? $clog2(RSV_TIMEOUT) : 1;

  logic [CNT_W-1:0] rsv_cnt;

  assign rsv_expire = rsv_valid && (rsv_cnt == CNT_W'(RSV_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsv_cnt <= '0;
    end else if (lr_set) begin
      rsv_cnt <= '0;
    end else if (rsv_valid && !rsv_expire) begin
      rsv_cnt <= rsv_cnt + 1'b1;
    end
  end
`else
  assign rsv_expire = 1'b0;
`endif

endmodule
